fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the MIPS core; sits directly upstream of control.
//  Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
//  Delivers instruction, PC+4 and a valid bit to ID. ifid_opcode drives control.opcode.
//  Accepts stall from the hazard unit and taken branch/jump/jal redirects from ID. No delay slot: redirect squashes.
// PARAMETERS
//  PC_WIDTH   32            width of PC, addresses and redirect target
//  RESET_PC   32'h00000000  PC value loaded on reset
//  NOP_INSTR  32'h00000000  instruction word placed in IF/ID for a bubble
// PORTS
//  clk          in   1         single clock; all state on rising edge
//  rst          in   1         asynchronous, active-high reset
//  stall        in   1         hold PC and IF/ID (load-use hazard)
//  redirect     in   1         taken beq / j / jal resolved in ID
//  redirect_pc  in   PC_WIDTH  target for redirect
//  imem_req     out  1         fetch request; imem_addr stable while high until imem_ready
//  imem_addr    out  PC_WIDTH  word address (= pc)
//  imem_ready   in   1         imem_rdata valid for current imem_addr this cycle
//  imem_rdata   in   32        fetched instruction word
//  ifid_instr   out  32        IF/ID instruction
//  ifid_pc4     out  PC_WIDTH  IF/ID PC+4 (branch base, jal link value)
//  ifid_valid   out  1         IF/ID holds a real instruction (0 = bubble)
//  ifid_opcode  out  6         ifid_instr[31:26], to control
//  fetch_count  out  32        instructions delivered to IF/ID since reset
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, state=FETCH, imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR,
//    ifid_pc4=0, fetch_count=0, saved target=0. imem_req=1 from first edge after rst deasserts, then always.
//  Request in flight: the request is open whenever imem_req=1; no new address until imem_ready=1.
//  imem_addr = pc, combinational. Zero cycles added after ready: the IF/ID update occurs on the edge of the ready cycle.
//  Priority each cycle: stall > redirect > normal.
//  State FETCH:
//   - stall=1: pc, IF/ID and fetch_count hold. A ready this cycle is ignored.
//     The request stays open and memory re-presents the same address. Redirect is ignored; ID reasserts it.
//   - redirect=1, ready=1: pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}; IF/ID <= bubble; fetched word dropped.
//   - redirect=1, ready=0: saved <= aligned redirect_pc; IF/ID <= bubble; state -> REDIR_PEND.
//   - ready=1: ifid_instr <= imem_rdata, ifid_pc4 <= pc+4, ifid_valid <= 1, pc <= pc+4, fetch_count++.
//   - ready=0: IF/ID <= bubble; pc holds.
//  State REDIR_PEND (stale request still open at old pc):
//   - redirect=1 (stall=0): saved <= new aligned target; latest wins.
//   - ready=1: data discarded, pc <= saved, state -> FETCH. IF/ID is not written from stale data.
//   - IF/ID: holds if stall=1, else bubble. Stall does not block the discard.
//  Bubble = ifid_valid 0, ifid_instr NOP_INSTR, ifid_pc4 unchanged.
//  Arithmetic: pc+4 wraps modulo 2^PC_WIDTH. fetch_count wraps modulo 2^32.
//   - redirect_pc[1:0] are forced to 00.
//  fetch_count increments only on a valid IF/ID load.
// STRUCTURE
//  Shared header mips_defs.vh:
//   - FSM state localparams: FETCH=1'b0, REDIR_PEND=1'b1.
//   - NOP word; opcode field range [31:26] shared with control.
//  One sub-module: ifid_reg, the IF/ID register with load / hold / bubble controls and async reset.
//  PC register, next-PC select, FSM and counter stay in fetch_stage.
// TESTING
//  1 Reset then ready=1 every cycle, rdata=addr+100 -> imem_addr 0,4,8; ifid_pc4 4,8,C; valid=1; fetch_count=3 after 3 edges.
//  2 stall=1 for 2 cycles with ready=1 at pc=8 -> pc stays 8, ifid_instr unchanged, count unchanged; resumes at 8 after stall drops.
//  3 redirect=1, redirect_pc=0x43 with ready=1 at pc=C -> next imem_addr=0x40, ifid_valid=0, count unchanged.
//  4 ready=0 at pc=10 plus redirect to 0x80, second redirect to 0x90 next cycle, ready 2 cycles later ->
//    imem_addr held 0x10 until ready, then 0x90; stale word never shows valid.
//  5 Assert rst mid-REDIR_PEND, asynchronous to clk -> outputs take reset values immediately; first fetch at RESET_PC.
//  6 Run from pc=0xFFFFFFFC with ready=1 -> ifid_pc4=0, next imem_addr=0 (wrap).

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared definitions for the fetch stage: FSM state encoding,
//               NOP word and the opcode field position that control decodes.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  // Fetch FSM: normal fetching, or waiting for a stale request to retire
  // before jumping to a saved redirect target.
  typedef enum logic [0:0] {
    FETCH      = 1'b0,
    REDIR_PEND = 1'b1
  } fetch_state_t;

  localparam logic [31:0] C_NOP_WORD = 32'h0000_0000;

  // Opcode field of a MIPS instruction word, shared with control.
  localparam int C_OPC_MSB = 31;
  localparam int C_OPC_LSB = 26;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register with load / bubble / hold controls.
//               load has priority over bubble; neither asserted means hold.
//               A bubble clears valid and writes NOP, leaving pc4 untouched.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               load, bubble     - update controls
//               instr_in, pc4_in - data captured on load
//               instr, pc4, valid- registered IF/ID contents
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg #(
  parameter int          PC_WIDTH  = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                bubble,
  input  logic [31:0]         instr_in,
  input  logic [PC_WIDTH-1:0] pc4_in,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc4,
  output logic                valid
);

  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc4;
  logic                r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_instr <= instr_in;
      r_pc4   <= pc4_in;
      r_valid <= 1'b1;
    end else if (bubble) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign instr = r_instr;
  assign pc4   = r_pc4;
  assign valid = r_valid;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with IF/ID register. Holds the PC,
//               issues word fetches over a req/ready handshake, applies
//               stall (hold) and redirect (squash, no delay slot).
// Ports       : clk, rst                 - clock, async active-high reset
//               stall, redirect,
//               redirect_pc              - hazard hold / taken branch target
//               imem_req, imem_addr,
//               imem_ready, imem_rdata   - instruction memory handshake
//               ifid_instr, ifid_pc4,
//               ifid_valid, ifid_opcode  - IF/ID contents to decode/control
//               fetch_count              - valid IF/ID loads since reset
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = C_NOP_WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc4,
  output logic                ifid_valid,
  output logic [5:0]          ifid_opcode,
  output logic [31:0]         fetch_count
);

  localparam logic [PC_WIDTH-1:0] c_pc_step    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] c_align_mask = ~(PC_WIDTH'(3));

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] r_saved;
  logic [PC_WIDTH-1:0] w_saved_nxt;
  logic                r_req;
  logic [31:0]         r_count;

  logic                w_ready;
  logic                w_load;
  logic                w_bubble;
  logic [PC_WIDTH-1:0] w_target;
  logic [PC_WIDTH-1:0] w_pc_plus4;

  // A ready only counts while a request is actually open.
  assign w_ready    = imem_ready & r_req;
  assign w_target   = redirect_pc & c_align_mask;
  assign w_pc_plus4 = r_pc + c_pc_step;

  // --------------------------------------------------------------------------
  // State / PC / saved-target / request registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_saved <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_saved <= w_saved_nxt;
      r_req   <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / next-PC / IF/ID control. Priority: stall > redirect > normal.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_saved_nxt = r_saved;
    w_load      = 1'b0;
    w_bubble    = 1'b0;

    unique case (r_state)
      FETCH: begin
        if (stall) begin
          // Hold everything; memory re-presents the same address later.
        end else if (redirect) begin
          w_bubble = 1'b1;
          if (w_ready) begin
            // The fetched word belongs to the squashed path: drop it.
            w_pc_nxt = w_target;
          end else begin
            // The old request must retire before the address may change.
            w_saved_nxt = w_target;
            w_state_nxt = REDIR_PEND;
          end
        end else if (w_ready) begin
          w_load   = 1'b1;
          w_pc_nxt = w_pc_plus4;
        end else begin
          w_bubble = 1'b1;
        end
      end

      REDIR_PEND: begin
        if (!stall) begin
          w_bubble = 1'b1;
          if (redirect) begin
            w_saved_nxt = w_target;
          end
        end
        // Stale data is discarded even under stall; latest target wins.
        if (w_ready) begin
          w_pc_nxt    = (redirect && !stall) ? w_target : r_saved;
          w_state_nxt = FETCH;
        end
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Delivered-instruction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= r_count + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID register
  // --------------------------------------------------------------------------
  ifid_reg #(
    .PC_WIDTH  (PC_WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .bubble   (w_bubble),
    .instr_in (imem_rdata),
    .pc4_in   (w_pc_plus4),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4),
    .valid    (ifid_valid)
  );

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign ifid_opcode = ifid_instr[C_OPC_MSB:C_OPC_LSB];
  assign fetch_count = r_count;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. Memory returns
//               address+100 for every word. Each check compares the packed
//               observation {req, addr, valid, instr, pc4, count, opcode}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  ifid_opcode;
  logic [31:0] fetch_count;

  int vecs = 0;
  int errs = 0;

  logic [135:0] obs;
  logic [135:0] exp_v;

  always #5 clk = ~clk;

  // Instruction memory model: word at address a is a+100.
  assign imem_rdata = imem_addr + 32'd100;

  assign obs = {imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_count, ifid_opcode};

  fetch_stage #(
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .ifid_opcode (ifid_opcode),
    .fetch_count (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(); step();
    exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    rst = 1'b0;
    step();
    exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL req_after_reset: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_sequential_and_stall();
    imem_ready = 1'b1;
    step();
    exp_v = {1'b1, 32'h4, 1'b1, 32'h64, 32'h4, 32'd1, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL fetch_0: got %h want %h", obs, exp_v); end
    step();
    exp_v = {1'b1, 32'h8, 1'b1, 32'h68, 32'h8, 32'd2, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL fetch_4: got %h want %h", obs, exp_v); end
    stall = 1'b1;
    step();
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL stall_1: got %h want %h", obs, exp_v); end
    step();
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL stall_2: got %h want %h", obs, exp_v); end
    stall = 1'b0;
    step();
    exp_v = {1'b1, 32'hC, 1'b1, 32'h6C, 32'hC, 32'd3, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL resume_8: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_redirect_ready();
    redirect = 1'b1; redirect_pc = 32'h43;
    step();
    exp_v = {1'b1, 32'h40, 1'b0, 32'h0, 32'hC, 32'd3, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL redirect_align: got %h want %h", obs, exp_v); end
    redirect_pc = 32'h10;
    step();
    exp_v = {1'b1, 32'h10, 1'b0, 32'h0, 32'hC, 32'd3, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL redirect_0x10: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_redirect_pending();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    step();
    exp_v = {1'b1, 32'h10, 1'b0, 32'h0, 32'hC, 32'd3, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL pend_enter: got %h want %h", obs, exp_v); end
    redirect_pc = 32'h90;
    step();
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL pend_second: got %h want %h", obs, exp_v); end
    redirect = 1'b0;
    step();
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL pend_wait: got %h want %h", obs, exp_v); end
    imem_ready = 1'b1;
    step();
    exp_v = {1'b1, 32'h90, 1'b0, 32'h0, 32'hC, 32'd3, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL pend_discard: got %h want %h", obs, exp_v); end
    step();
    exp_v = {1'b1, 32'h94, 1'b1, 32'hF4, 32'h94, 32'd4, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL fetch_0x90: got %h want %h", obs, exp_v); end
    // Stall must not block the discard of a stale word.
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    exp_v = {1'b1, 32'h94, 1'b0, 32'h0, 32'h94, 32'd4, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL pend_0x200: got %h want %h", obs, exp_v); end
    stall = 1'b1; imem_ready = 1'b1; redirect = 1'b0;
    step();
    exp_v = {1'b1, 32'h200, 1'b0, 32'h0, 32'h94, 32'd4, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL discard_under_stall: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    stall = 1'b0; imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
    step();
    exp_v = {1'b1, 32'h200, 1'b0, 32'h0, 32'h94, 32'd4, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL pend_0x300: got %h want %h", obs, exp_v); end
    #2;
    rst = 1'b1;
    #1;
    exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL async_reset: got %h want %h", obs, exp_v); end
    redirect = 1'b0; imem_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL req_after_async: got %h want %h", obs, exp_v); end
    step();
    exp_v = {1'b1, 32'h4, 1'b1, 32'h64, 32'h4, 32'd1, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL first_fetch_reset_pc: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    exp_v = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h4, 32'd1, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL redirect_top: got %h want %h", obs, exp_v); end
    redirect = 1'b0;
    step();
    exp_v = {1'b1, 32'h0, 1'b1, 32'h60, 32'h0, 32'd2, 6'h0};
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL pc_wrap: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_sequential_and_stall();
    test_redirect_ready();
    test_redirect_pending();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
